// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: receive-side checker for the VGA pixel stream.
// Locks onto the sync timing, rebuilds pixel coordinates from hsync/vsync,
// checks every line/frame length and reports a per-frame signature and a
// count of non-black pixels.
//
// Ports
//   clk          pixel clock (same clock as the generator)
//   reset        synchronous, active-high
//   hsync/vsync  sync inputs, asserted level SYNC_ACTIVE
//   rrggbb       pixel colour
//   x_px/y_px    coordinates of the registered pixel (0 when !active)
//   active       registered pixel is inside the active window
//   locked       timing matches the parameters
//   timing_err   1-cycle pulse when a violation drops the lock
//   frame_valid  1-cycle pulse when frame_sig/frame_lit update
//   frame_sig    signature of the last complete locked frame
//   frame_lit    nonzero-pixel count of that frame
module vga_rx_monitor #(
  parameter int H_TOTAL     = 832,
  parameter int H_START     = 168,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 520,
  parameter int V_START     = 31,
  parameter int V_ACTIVE    = 480,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [5:0]  rrggbb,
  output logic [9:0]  x_px,
  output logic [9:0]  y_px,
  output logic        active,
  output logic        locked,
  output logic        timing_err,
  output logic        frame_valid,
  output logic [15:0] frame_sig,
  output logic [18:0] frame_lit
);
  localparam logic [10:0] HTOT = 11'(H_TOTAL);
  localparam logic [10:0] VTOT = 11'(V_TOTAL);
  localparam logic [10:0] H_LO = 11'(H_START);
  localparam logic [10:0] H_HI = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] V_LO = 11'(V_START);
  localparam logic [10:0] V_HI = 11'(V_START + V_ACTIVE);
  localparam logic [9:0]  H_OFF = 10'(H_START);
  localparam logic [9:0]  V_OFF = 10'(V_START);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state, state_nx;
  logic        hs_r, vs_r, hs_d, vs_d;
  logic [5:0]  pix_r;
  logic        h_edge, v_edge;
  logic [9:0]  h_cnt, v_cnt, h_cur, v_cur;
  logic        line_bad, frame_bad, sat_hit, fault;
  logic        meas_bad, full_frame, report;
  logic [15:0] sig;
  logic [18:0] lit;

  // Input stage; sync copies reset to the inactive level so the first
  // assertion after reset is seen as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_r  <= ~SYNC_ACTIVE;
      vs_r  <= ~SYNC_ACTIVE;
      hs_d  <= ~SYNC_ACTIVE;
      vs_d  <= ~SYNC_ACTIVE;
      pix_r <= '0;
    end else begin
      hs_r  <= hsync;
      vs_r  <= vsync;
      hs_d  <= hs_r;
      vs_d  <= vs_r;
      pix_r <= rrggbb;
    end
  end

  assign h_edge = (hs_r == SYNC_ACTIVE) && (hs_d != SYNC_ACTIVE);
  assign v_edge = (vs_r == SYNC_ACTIVE) && (vs_d != SYNC_ACTIVE);

  // h_cur/v_cur are the coordinates of the pixel now in pix_r; the
  // registered h_cnt/v_cnt hold the previous cycle's values.
  always_comb begin
    h_cur = (h_cnt == 10'h3FF) ? h_cnt : h_cnt + 10'd1;
    if (h_edge) h_cur = '0;
    v_cur = v_cnt;
    if (h_edge && (v_cnt != 10'h3FF)) v_cur = v_cnt + 10'd1;
    if (v_edge) v_cur = '0;
  end

  assign line_bad  = h_edge && (({1'b0, h_cnt} + 11'd1) != HTOT);
  assign frame_bad = v_edge && (({1'b0, v_cnt} + 11'd1) != VTOT);
  assign sat_hit   = (&h_cur) || (&v_cur);
  assign fault     = line_bad || frame_bad || sat_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_cur;
      v_cnt <= v_cur;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= SEARCH;
    else       state <= state_nx;
  end

  // FSM: next state. A bad line inside MEASURE taints the whole measurement,
  // including the line that closes at the vsync edge itself.
  always_comb begin
    state_nx = state;
    unique case (state)
      SEARCH:  if (v_edge) state_nx = MEASURE;
      MEASURE: if (v_edge && !frame_bad && !line_bad && !meas_bad) state_nx = LOCKED;
      LOCKED:  if (fault) state_nx = SEARCH;
      default: state_nx = SEARCH;
    endcase
  end

  // FSM: outputs
  always_comb begin
    locked     = (state == LOCKED);
    timing_err = locked && fault;
    report     = locked && v_edge && !fault && full_frame;
  end

  // Every vsync edge starts a fresh measurement.
  always_ff @(posedge clk) begin
    if (reset || v_edge)                    meas_bad <= 1'b0;
    else if (state == MEASURE && line_bad)  meas_bad <= 1'b1;
  end

  // Set when lock is gained at a vsync edge, so the accumulators start on a
  // frame boundary and the next clean vsync edge closes a complete frame.
  always_ff @(posedge clk) begin
    if (reset || timing_err)                          full_frame <= 1'b0;
    else if (state == MEASURE && state_nx == LOCKED)  full_frame <= 1'b1;
  end

  always_comb begin
    active = locked && ({1'b0, h_cur} >= H_LO) && ({1'b0, h_cur} < H_HI)
                    && ({1'b0, v_cur} >= V_LO) && ({1'b0, v_cur} < V_HI);
    x_px   = active ? h_cur - H_OFF : '0;
    y_px   = active ? v_cur - V_OFF : '0;
  end

  always_ff @(posedge clk) begin
    if (reset || timing_err || report) begin
      sig <= '0;
      lit <= '0;
    end else if (active) begin
      sig <= {sig[14:0], sig[15]} ^ {10'b0, pix_r};
      lit <= lit + 19'(pix_r != 6'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_valid <= 1'b0;
      frame_sig   <= '0;
      frame_lit   <= '0;
    end else begin
      frame_valid <= report;
      if (report) begin
        frame_sig <= sig;
        frame_lit <= lit;
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a shrunken 20x12 timing
// (4 + 8 active clocks per line, 3 + 6 active lines per frame).
module tb_vga_rx_monitor;
  localparam int HT = 20, HS = 4, HA = 8;
  localparam int VT = 12, VS = 3, VA = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsync = 1'b1, vsync = 1'b1;
  logic [5:0]  rrggbb = '0;
  logic [9:0]  x_px, y_px;
  logic        active, locked, timing_err, frame_valid;
  logic [15:0] frame_sig;
  logic [18:0] frame_lit;

  vga_rx_monitor #(
    .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA), .SYNC_ACTIVE(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rrggbb(rrggbb),
    .x_px(x_px), .y_px(y_px), .active(active), .locked(locked),
    .timing_err(timing_err), .frame_valid(frame_valid),
    .frame_sig(frame_sig), .frame_lit(frame_lit)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int fv_cnt = 0, te_cnt = 0;
  int gh = 0, gv = 0, drv_h = -1, drv_v = -1, obs_h = -1, obs_v = -1;
  int mode = 0;
  bit gen_en = 1'b0, gen_stuck = 1'b0, stretch_once = 1'b0;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (timing_err === 1'b1)  te_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pixel patterns: 0 black, 1 single 3F at (0,0) of the window,
  // 2 whole window 3F, 3 value 01 at the last active pixel with 3F just
  // outside each window edge.
  function automatic logic [5:0] pix_at(int m, int h, int v);
    logic [5:0] p;
    p = 6'h00;
    case (m)
      1: if (h == HS && v == VS) p = 6'h3F;
      2: if (h >= HS && h < HS + HA && v >= VS && v < VS + VA) p = 6'h3F;
      3: begin
        if (h == HS + HA - 1 && v == VS + VA - 1) p = 6'h01;
        if ((h == HS - 1 && v == 8) || (h == HS + HA && v == 8) ||
            (h == 11 && v == VS - 1) || (h == 11 && v == VS + VA)) p = 6'h3F;
      end
      default: p = 6'h00;
    endcase
    return p;
  endfunction

  // One cycle: at the falling edge record which pixel the DUT now shows,
  // then drive the next generator pixel.
  task automatic tick();
    int len;
    @(negedge clk);
    obs_h = drv_h;
    obs_v = drv_v;
    if (gen_en && !gen_stuck) begin
      hsync  = (gh < 2) ? 1'b0 : 1'b1;
      vsync  = (gv < 2) ? 1'b0 : 1'b1;
      rrggbb = pix_at(mode, gh, gv);
      drv_h  = gh;
      drv_v  = gv;
      len    = (stretch_once && gv == 5) ? HT + 1 : HT;
      gh++;
      if (gh == len) begin
        if (len != HT) stretch_once = 1'b0;
        gh = 0;
        gv = (gv == VT - 1) ? 0 : gv + 1;
      end
    end else begin
      hsync  = 1'b1;
      vsync  = 1'b1;
      rrggbb = 6'h00;
      drv_h  = -1;
      drv_v  = -1;
    end
  endtask

  task automatic run_frame();
    do tick(); while (!(gh == 0 && gv == 0));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic run_to(input int h, input int v);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      if (obs_h == h && obs_v == v) found = 1'b1;
    end
    if (!found) begin
      n_chk++;
      n_fail++;
      $error("FAIL run_to: observed no pixel (%0d,%0d) expected within 2000 cycles", h, v);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_locked", locked, 0);
    chk("rst_active", active, 0);
    chk("rst_xy", {x_px, y_px}, 0);
    chk("rst_terr", timing_err, 0);
    chk("rst_fvalid", frame_valid, 0);
    chk("rst_fsig", frame_sig, 0);
    chk("rst_flit", frame_lit, 0);
    reset  = 1'b0;
    gen_en = 1'b1;

    // Lock sequence: edge 1 -> MEASURE, edge 2 -> LOCKED
    run_frame();                       // frame 0
    chk("f0_locked", locked, 0);
    run_to(0, 0);
    chk("edge2_locked_pre", locked, 0);
    run_to(1, 0);
    chk("edge2_locked_post", locked, 1);
    run_frame();                       // rest of frame 1
    chk("f1_no_fvalid", fv_cnt, 0);

    // Frame 2: single pixel, window edges
    mode = 1;
    run_to(HS - 1, VS);
    chk("win_left_out", active, 0);
    run_to(HS, VS);
    chk("win_first_act", active, 1);
    chk("win_first_x", x_px, 0);
    chk("win_first_y", y_px, 0);
    chk("first_fvalid", fv_cnt, 1);
    chk("black_sig", frame_sig, 16'h0000);
    chk("black_lit", frame_lit, 0);
    run_to(HS + HA - 1, VS + VA - 1);
    chk("win_last_act", active, 1);
    chk("win_last_xy", {x_px, y_px}, {10'd7, 10'd5});
    run_to(HS + HA, VS + VA - 1);
    chk("win_right_out", active, 0);
    chk("win_right_x", x_px, 0);
    run_to(HS, VS + VA);
    chk("win_bottom_out", active, 0);
    run_frame();

    mode = 3;
    run_frame();                       // frame 3
    chk("single_fv", fv_cnt, 2);
    chk("single_sig", frame_sig, 16'h801F);
    chk("single_lit", frame_lit, 1);

    mode = 2;
    run_frame();                       // frame 4
    chk("guard_sig", frame_sig, 16'h0001);
    chk("guard_lit", frame_lit, 1);
    run_frame();                       // frame 5
    chk("full_sig", frame_sig, 16'h0000);
    chk("full_lit", frame_lit, HA * VA);
    mode = 0;
    run_frame();                       // frame 6
    chk("repeat_sig", frame_sig, 16'h0000);
    chk("repeat_lit", frame_lit, HA * VA);
    chk("repeat_fv", fv_cnt, 5);

    // Frame 7: line 5 stretched by one clock
    stretch_once = 1'b1;
    run_frame();
    chk("stretch_terr", te_cnt, 1);
    chk("stretch_unlock", locked, 0);
    chk("stretch_fv_prev", fv_cnt, 6);
    run_frame();                       // frame 8: MEASURE
    chk("stretch_no_fv", fv_cnt, 6);
    chk("stretch_measure", locked, 0);
    run_frame();                       // frame 9: relocked
    chk("relock", locked, 1);
    chk("relock_no_fv", fv_cnt, 6);
    run_frame();                       // frame 10
    chk("relock_fv", fv_cnt, 7);
    chk("relock_terr", te_cnt, 1);

    // Both syncs stuck inactive: h_cnt runs to saturation
    gen_stuck = 1'b1;
    repeat (900) tick();
    chk("stuck_still_locked", locked, 1);
    chk("stuck_no_terr_yet", te_cnt, 1);
    repeat (200) tick();
    chk("sat_terr", te_cnt, 2);
    chk("sat_unlock", locked, 0);
    repeat (300) tick();
    chk("sat_stays_unlocked", locked, 0);
    chk("sat_single_terr", te_cnt, 2);
    chk("sat_no_fv", fv_cnt, 7);

    // Recover, then reset mid-frame
    gen_stuck = 1'b0;
    run_frame();                       // frame 11: MEASURE
    mode = 1;
    run_frame();                       // frame 12: LOCKED
    chk("recover_locked", locked, 1);
    mode = 0;
    run_to(6, 5);
    chk("mid_fv", fv_cnt, 8);
    chk("mid_sig", frame_sig, 16'h801F);
    chk("mid_act", active, 1);
    chk("mid_xy", {x_px, y_px}, {10'd2, 10'd2});
    reset  = 1'b1;
    gen_en = 1'b0;
    tick();
    chk("mrst_locked", locked, 0);
    chk("mrst_active", active, 0);
    chk("mrst_xy", {x_px, y_px}, 0);
    chk("mrst_fsig", frame_sig, 0);
    chk("mrst_flit", frame_lit, 0);
    chk("mrst_fvalid", frame_valid, 0);
    chk("mrst_terr", timing_err, 0);
    tick();
    reset  = 1'b0;
    gh     = 0;
    gv     = 0;
    gen_en = 1'b1;
    run_frame();
    chk("rl_f0_locked", locked, 0);
    run_frame();
    chk("rl_f1_locked", locked, 1);
    chk("rl_f1_fv", fv_cnt, 8);
    run_frame();
    chk("rl_f2_fv", fv_cnt, 9);
    chk("rl_f2_sig", frame_sig, 16'h0000);
    chk("rl_terr", te_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
